led_arbiter: RTL
================

Name: led_arbiter

Overview:
- Shares the board's 2-bit status LED bank between NREQ independent requesters, e.g. link-up, packet activity, error and debug sources.
- Arbitration is round-robin, with a minimum visible hold time per grant.
- Each requester selects which LEDs it drives and a display mode: off, on, slow blink or fast blink.
- When no requester is active, led[0] shows a heartbeat.
- Sits between status sources and the top-level led[1:0] pins, on the single system clock after the differential input buffer.

Parameters:
- CLK_HZ, 200000000: sys_clk frequency in Hz.
- TICK_HZ, 1000: internal tick rate in Hz (1 ms). The prescale value CLK_HZ/TICK_HZ must be an integer ≥2.
- NREQ, 4: number of requesters, 2..8.
- HOLD_TICKS, 500: minimum number of ticks a grant is displayed.
- BLINK_TICKS, 250: slow-blink half-period in ticks. Fast blink half-period is BLINK_TICKS/4, which must be ≥1.
- HB_TICKS, 500: idle heartbeat half-period in ticks.

Ports:
- sys_clk, input, 1: system clock. Single clock domain.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, NREQ: request level, one bit per requester.
- req_mode, input, 2*NREQ: mode for requester i in bits [2i+1:2i]. 00 = off, 01 = on, 10 = slow blink, 11 = fast blink.
- req_led, input, 2*NREQ: LED mask for requester i in bits [2i+1:2i]. A set bit means that LED is driven.
- gnt, output, NREQ: one-hot grant. All zero when idle.
- busy, output, 1: high while any grant is active.
- led, output, 2: LED drive, active high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - led=00, gnt=0, busy=0.
  - State IDLE; round-robin pointer rr=0.
  - Prescaler, hold, blink and heartbeat counters all 0.
  - Heartbeat phase 0.
- Prescaler:
  - Free-running counter 0..CLK_HZ/TICK_HZ-1, width $clog2(CLK_HZ/TICK_HZ).
  - tick is a 1-cycle pulse when the counter wraps.
  - All ms-domain counters advance only on tick.
- States: IDLE, ARB, GRANT.
- IDLE:
  - led = {1'b0, hb}. hb toggles every HB_TICKS ticks.
  - gnt=0, busy=0.
  - If |req, go to ARB on the next cycle.
- ARB (exactly 1 cycle):
  - Winner w = first set bit of req, searching from index rr upward and wrapping modulo NREQ.
  - Latch req_mode[w] and req_led[w].
  - On the next edge: gnt=onehot(w), busy=1, hold_cnt=0, blink counters=0, blink phase=on, state GRANT.
  - If req==0 during ARB (request withdrawn), return to IDLE with gnt unchanged at 0.
  - Latency: req rising in IDLE at edge N gives gnt/led valid after edge N+2.
- GRANT:
  - For each LED b: if the latched mask bit b is set, led[b] follows the latched mode; otherwise led[b]=0.
  - Slow blink toggles every BLINK_TICKS ticks; fast blink every BLINK_TICKS/4 ticks.
  - hold_cnt increments on tick and saturates at HOLD_TICKS.
  - Mode and mask are frozen for the whole grant. A holder changing its inputs has no effect until its next grant.
  - Release condition, evaluated each cycle once hold_cnt==HOLD_TICKS:
    - If req[w]==0, release.
    - If req[w]==1 and any other req bit is set, release.
    - If req[w]==1 and it is the only requester, keep the grant indefinitely.
  - On release: rr=(w+1) mod NREQ, gnt=0, busy=0, led=00 for that cycle.
  - After release: go to ARB if |req, else IDLE.
  - A request dropped before the hold expires still gets the full HOLD_TICKS of display.
- Heartbeat counter runs only in IDLE and resets to 0 on leaving IDLE.
- Simultaneous events:
  - The release evaluation and the ARB selection both use the req value sampled in that cycle.
  - A requester that drops and reasserts within the same hold window is treated as continuously requesting.

Optional Feature:
- LED_ARB_PRIO_EN defined:
  - Requester 0 pre-empts. If req[0] rises while another requester holds GRANT, the grant is released on the next cycle, ignoring hold_cnt.
  - ARB is then forced to pick w=0, and rr is set to 1.
  - A requester 0 grant is never pre-empted.
- LED_ARB_PRIO_EN undefined: pure round-robin as above. Requester 0 has no special treatment.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), NREQ=4, HOLD_TICKS=5, BLINK_TICKS=4, HB_TICKS=3.
- Reset then idle, req=0 → led=00, gnt=0 during reset; after release led[0] toggles every 30 cycles, led[1]=0, busy=0.
- req=0001, mode0=01, mask0=11, asserted after edge 100 → gnt=0001 and led=11 after edge 102; held as long as req[0] stays high and no other requester asserts.
- req=0110 held continuously, both modes=01 → gnt alternates 0010 and 0100. Each grant lasts ≥50 cycles, with one led=00/gnt=0 cycle plus one ARB cycle between grants.
- req[2] one-cycle pulse, mode2=11, mask2=01 → gnt=0100 for 5 ticks; led[0] toggles every 10 cycles; then IDLE with heartbeat.
- Grant active with mode=10, rst_n pulsed low mid-grant → led=00, gnt=0, busy=0 immediately (asynchronous); after reset, rr=0.
- With LED_ARB_PRIO_EN: req[3] granted and held, then req[0] asserted at hold_cnt=1 → gnt=0000 on the next cycle, then gnt=0001 within 2 further cycles. Without the macro: req[3] keeps the grant until hold_cnt=5.

Source files
------------

// File: rtl/led_arbiter.sv
// led_arbiter: shares the 2-bit status LED bank between NREQ requesters.
// Round-robin arbitration, a minimum hold per grant, per-requester
// off/on/slow/fast display modes, and an idle heartbeat on led[0].
// Optional feature macro: LED_ARB_PRIO_EN (requester 0 pre-empts).

module led_arbiter #(
  parameter int unsigned CLK_HZ      = 200000000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_TICKS  = 500,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned HB_TICKS    = 500
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [2*NREQ-1:0] req_led,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [1:0]        led
);

  localparam int unsigned PRESC      = CLK_HZ / TICK_HZ;
  localparam int unsigned FAST_TICKS = BLINK_TICKS / 4;
  localparam int unsigned PW = $clog2(PRESC);
  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned SW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned FW = (FAST_TICKS > 1) ? $clog2(FAST_TICKS) : 1;
  localparam int unsigned BW = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
  localparam int unsigned RW = $clog2(NREQ);

  // REL is the one blank cycle (gnt=0, led=00) that follows every grant
  // before the next arbitration.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    REL   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [RW-1:0]   rr_q, rr_d;
  logic [RW-1:0]   win_q, win_d;
  logic [1:0]      mode_q, mode_d;
  logic [1:0]      mask_q, mask_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [SW-1:0]   slow_cnt_q, slow_cnt_d;
  logic            slow_ph_q, slow_ph_d;
  logic [FW-1:0]   fast_cnt_q, fast_cnt_d;
  logic            fast_ph_q, fast_ph_d;
  logic [BW-1:0]   hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [1:0]      led_q, led_d;

  logic [1:0]      mode_arr [NREQ];
  logic [1:0]      mask_arr [NREQ];
  logic [RW-1:0]   cand;
  logic [RW-1:0]   pick;
  logic            pick_vld;
  logic            others_req;
  logic            release_now;
  logic            lit;

  assign tick    = (presc_q == PW'(PRESC - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  for (genvar g = 0; g < NREQ; g++) begin : g_fields
    assign mode_arr[g] = req_mode[2*g +: 2];
    assign mask_arr[g] = req_led[2*g +: 2];
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = RW'((32'(rr_q) + k) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
`ifdef LED_ARB_PRIO_EN
    if (req[0]) begin
      pick_vld = 1'b1;
      pick     = '0;
    end
`endif
  end

  always_comb begin
    others_req  = |(req & ~(NREQ'(1) << win_q));
    release_now = (hold_q == HW'(HOLD_TICKS)) && (!req[win_q] || others_req);
`ifdef LED_ARB_PRIO_EN
    if ((win_q != '0) && req[0]) begin
      release_now = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    hold_d     = hold_q;
    slow_cnt_d = slow_cnt_q;
    slow_ph_d  = slow_ph_q;
    fast_cnt_d = fast_cnt_q;
    fast_ph_d  = fast_ph_q;
    hb_cnt_d   = hb_cnt_q;
    hb_d       = hb_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (hb_cnt_q == BW'(HB_TICKS - 1)) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
          end else begin
            hb_cnt_d = hb_cnt_q + 1'b1;
          end
        end
        if (|req) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (pick_vld) begin
          state_d    = GRANT;
          win_d      = pick;
          mode_d     = mode_arr[pick];
          mask_d     = mask_arr[pick];
          hold_d     = '0;
          slow_cnt_d = '0;
          fast_cnt_d = '0;
          slow_ph_d  = 1'b1;
          fast_ph_d  = 1'b1;
`ifdef LED_ARB_PRIO_EN
          if (req[0]) begin
            rr_d = RW'(1);
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = REL;
          rr_d    = (win_q == RW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        end else if (tick) begin
          if (hold_q != HW'(HOLD_TICKS)) begin
            hold_d = hold_q + 1'b1;
          end
          if (slow_cnt_q == SW'(BLINK_TICKS - 1)) begin
            slow_cnt_d = '0;
            slow_ph_d  = ~slow_ph_q;
          end else begin
            slow_cnt_d = slow_cnt_q + 1'b1;
          end
          if (fast_cnt_q == FW'(FAST_TICKS - 1)) begin
            fast_cnt_d = '0;
            fast_ph_d  = ~fast_ph_q;
          end else begin
            fast_cnt_d = fast_cnt_q + 1'b1;
          end
        end
      end
      REL: begin
        state_d = (|req) ? ARB : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != IDLE) begin
      hb_cnt_d = '0;
    end
  end

  always_comb begin
    case (mode_d)
      2'b01:   lit = 1'b1;
      2'b10:   lit = slow_ph_d;
      2'b11:   lit = fast_ph_d;
      default: lit = 1'b0;
    endcase
    gnt_d  = '0;
    busy_d = 1'b0;
    led_d  = '0;
    case (state_d)
      IDLE: begin
        led_d = {1'b0, hb_d};
      end
      GRANT: begin
        gnt_d  = NREQ'(1) << win_d;
        busy_d = 1'b1;
        led_d  = mask_d & {2{lit}};
      end
      default: begin
        led_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      rr_q       <= '0;
      win_q      <= '0;
      mode_q     <= '0;
      mask_q     <= '0;
      hold_q     <= '0;
      slow_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      fast_cnt_q <= '0;
      fast_ph_q  <= 1'b0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      hold_q     <= hold_d;
      slow_cnt_q <= slow_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_cnt_q <= fast_cnt_d;
      fast_ph_q  <= fast_ph_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign led  = led_q;

endmodule
